// File: rtl/mandelbrot_cfg_pkg.sv
// Shared definitions for the Mandelbrot core configuration path: word layout,
// frame-scheduler state encoding and a small constant helper.
package mandelbrot_cfg_pkg;

    localparam int CFG_WIDTH = 57;

    // Config word field map (LSB offset / width)
    localparam int X_LSB        = 0;
    localparam int X_W          = 16;
    localparam int Y_LSB        = 16;
    localparam int Y_W          = 16;
    localparam int SCALE_LSB    = 32;
    localparam int SCALE_W      = 7;
    localparam int MODE_LSB     = 39;
    localparam int MODE_W       = 3;
    localparam int MAX_ITER_LSB = 42;
    localparam int MAX_ITER_W   = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } cfg_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cfg_rr_arbiter.sv
// Two-way round-robin grant between the host loader (A) and the preset
// stepper (B). On a tie the side that was not served last wins.
module cfg_rr_arbiter
    import mandelbrot_cfg_pkg::*;
(
    input  logic enable,
    input  logic a_valid,
    input  logic b_valid,
    input  logic last_src,
    output logic a_ready,
    output logic b_ready
);

    // Grant only while the scheduler can take a word
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (enable) begin
            a_ready = a_valid && (!b_valid || last_src);
            b_ready = b_valid && (!a_valid || !last_src);
        end else begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
    end

endmodule

// File: rtl/cfg_frame_scheduler.sv
// Serial configuration controller: takes a word from A or B and shifts it
// LSB-first onto the core's enable/sclk/data port as one framed burst.
// Data only moves on the falling sclk edge, so the core samples on the rise.
module cfg_frame_scheduler
    import mandelbrot_cfg_pkg::*;
#(
    parameter int CFG_WIDTH  = mandelbrot_cfg_pkg::CFG_WIDTH,
    parameter int SCLK_DIV   = 1,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [CFG_WIDTH-1:0] a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [CFG_WIDTH-1:0] b_data,
    output logic                 b_ready,
    output logic                 cfg_en,
    output logic                 cfg_sclk,
    output logic                 cfg_data,
    output logic                 busy,
    output logic                 done,
    output logic                 last_src
);

    localparam int BIT_W = $clog2(CFG_WIDTH + 1);
    localparam int DIV_W = $clog2(max_int(SCLK_DIV, GAP_CYCLES) + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_WIDTH);

    cfg_state_e           state_r, state_s;
    logic [DIV_W-1:0]     div_r, div_s;
    logic [BIT_W-1:0]     bit_r, bit_s;
    logic [CFG_WIDTH-1:0] shift_r, shift_s;
    logic                 last_src_r, last_src_s;
    logic                 cfg_en_r, cfg_en_s;
    logic                 cfg_sclk_r, cfg_sclk_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic                 a_ready_s, b_ready_s;

    cfg_rr_arbiter u_arb (
        .enable   (state_r == ST_IDLE),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .last_src (last_src_r),
        .a_ready  (a_ready_s),
        .b_ready  (b_ready_s)
    );

    // Frame sequencing: accept, setup, sclk high/low per bit, then gap
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        last_src_s = last_src_r;
        case (state_r)
            ST_IDLE: begin
                if (a_ready_s || b_ready_s) begin
                    shift_s    = b_ready_s ? b_data : a_data;
                    last_src_s = b_ready_s;
                    bit_s      = {BIT_W{1'b0}};
                    div_s      = {DIV_W{1'b0}};
                    state_s    = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (div_r == DIV_LAST) begin
                    div_s   = {DIV_W{1'b0}};
                    state_s = ST_HIGH;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (div_r == DIV_LAST) begin
                    shift_s = {1'b0, shift_r[CFG_WIDTH-1:1]};
                    bit_s   = bit_r + BIT_W'(1);
                    div_s   = {DIV_W{1'b0}};
                    state_s = ST_LOW;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            ST_LOW: begin
                if (div_r == DIV_LAST) begin
                    div_s = {DIV_W{1'b0}};
                    if (bit_r == BIT_LAST) begin
                        state_s = ST_GAP;
                    end else begin
                        state_s = ST_HIGH;
                    end
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (div_r == GAP_LAST) begin
                    div_s   = {DIV_W{1'b0}};
                    state_s = ST_IDLE;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                div_s   = {DIV_W{1'b0}};
                bit_s   = {BIT_W{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state
    always_comb begin
        cfg_en_s   = 1'b0;
        cfg_sclk_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_s)
            ST_SETUP: begin
                cfg_en_s = 1'b1;
                busy_s   = 1'b1;
            end
            ST_HIGH: begin
                cfg_en_s   = 1'b1;
                cfg_sclk_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_LOW: begin
                cfg_en_s = 1'b1;
                busy_s   = 1'b1;
                done_s   = (bit_s == BIT_LAST) && (div_s == DIV_LAST);
            end
            ST_GAP: begin
                busy_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset abandons any frame in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            div_r      <= {DIV_W{1'b0}};
            bit_r      <= {BIT_W{1'b0}};
            shift_r    <= {CFG_WIDTH{1'b0}};
            last_src_r <= 1'b1;
            cfg_en_r   <= 1'b0;
            cfg_sclk_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            last_src_r <= last_src_s;
            cfg_en_r   <= cfg_en_s;
            cfg_sclk_r <= cfg_sclk_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign a_ready  = a_ready_s;
    assign b_ready  = b_ready_s;
    assign cfg_en   = cfg_en_r;
    assign cfg_sclk = cfg_sclk_r;
    assign cfg_data = shift_r[0];
    assign busy     = busy_r;
    assign done     = done_r;
    assign last_src = last_src_r;

endmodule

// File: tb/tb_cfg_frame_scheduler.sv
// Bench for cfg_frame_scheduler: two instances (SCLK_DIV=1/GAP=1 and
// SCLK_DIV=3/GAP=4) driven by random requesters; each cycle of a frame is
// compared against a waveform computed arithmetically from the frame timing.
module tb_cfg_frame_scheduler;
    import mandelbrot_cfg_pkg::*;

    localparam int W       = CFG_WIDTH;
    localparam int NFRAMES = 10;
    localparam int RST_FRM = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int fin_count = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DIV       = (g == 0) ? 1 : 3;
        localparam int GAP       = (g == 0) ? 1 : 4;
        localparam int EN_CYC    = DIV * (2 * W + 1);
        localparam int FRAME_CYC = EN_CYC + GAP;

        logic         reset;
        logic         a_valid, b_valid;
        logic [W-1:0] a_data, b_data;
        logic         a_ready, b_ready, cfg_en, cfg_sclk, cfg_data, busy, done, last_src;

        cfg_frame_scheduler #(.CFG_WIDTH(W), .SCLK_DIV(DIV), .GAP_CYCLES(GAP)) dut (
            .clk(clk), .reset(reset),
            .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
            .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
            .cfg_en(cfg_en), .cfg_sclk(cfg_sclk), .cfg_data(cfg_data),
            .busy(busy), .done(done), .last_src(last_src)
        );

        function automatic logic [W-1:0] rand_word();
            return W'({$urandom(), $urandom()});
        endfunction

        // {cfg_en, cfg_sclk, cfg_data, busy, done} at cycle k after the accept edge
        function automatic logic [4:0] expect_wave(input int k, input logic [W-1:0] w);
            int   j;
            int   b;
            logic dat;
            if (k <= DIV) return {1'b1, 1'b0, w[0], 1'b1, 1'b0};
            if (k <= EN_CYC) begin
                j = k - DIV - 1;
                b = j / (2 * DIV);
                if ((j % (2 * DIV)) < DIV) return {1'b1, 1'b1, w[b], 1'b1, 1'b0};
                dat = (b + 1 < W) ? w[b + 1] : 1'b0;
                return {1'b1, 1'b0, dat, 1'b1, ((b == W - 1) && ((j % (2 * DIV)) == 2 * DIV - 1))};
            end
            if (k <= FRAME_CYC) return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            return 5'b00000;
        endfunction

        initial begin : stim
            logic         mdl_last;
            logic         win;
            logic         aborted;
            logic         prev_sclk;
            logic [W-1:0] w;
            logic [W-1:0] coll;
            int           nrise;
            int           sel;

            reset   = 1'b1;
            a_valid = 1'b0;
            b_valid = 1'b0;
            a_data  = {W{1'b0}};
            b_data  = {W{1'b0}};
            repeat (3) @(posedge clk);
            @(negedge clk);
            #1;
            check_value($sformatf("i%0d_reset", g),
                        {cfg_en, cfg_sclk, cfg_data, busy, done, a_ready, b_ready, last_src}, 8'b0000_0001);
            @(negedge clk);
            reset    = 1'b0;
            mdl_last = 1'b1;

            for (int f = 0; f < NFRAMES; f++) begin
                // At a negedge with the scheduler idle: make sure someone requests
                if (!a_valid && !b_valid) begin
                    sel = $urandom_range(0, 2);
                    if (f == 0) sel = (g == 0) ? 0 : 2;
                    if (sel != 1) begin
                        a_valid = 1'b1;
                        a_data  = (f == 0 && g == 0) ? 57'h00F_B500_6080 : rand_word();
                    end
                    if (sel != 0) begin
                        b_valid = 1'b1;
                        b_data  = rand_word();
                    end
                end
                #1;
                win = (a_valid && b_valid) ? !mdl_last : b_valid;
                check_value($sformatf("i%0d_f%0d_idle", g, f),
                            {cfg_en, cfg_sclk, cfg_data, busy, done, a_ready, b_ready, last_src},
                            {5'b00000, a_valid && !win, b_valid && win, mdl_last});
                w = win ? b_data : a_data;
                @(posedge clk);
                mdl_last  = win;
                aborted   = 1'b0;
                coll      = {W{1'b0}};
                nrise     = 0;
                prev_sclk = 1'b0;

                for (int k = 1; k <= FRAME_CYC && !aborted; k++) begin
                    @(negedge clk);
                    if (k == 1) begin
                        if (win) b_valid = 1'b0; else a_valid = 1'b0;
                    end
                    if (k == 2 && $urandom_range(0, 1) == 1) begin
                        if (win && !a_valid) begin a_valid = 1'b1; a_data = rand_word(); end
                        if (!win && !b_valid) begin b_valid = 1'b1; b_data = rand_word(); end
                    end
                    if (k == 3 && $urandom_range(0, 1) == 1) begin
                        if (win) begin b_valid = 1'b1; b_data = rand_word(); end
                        else begin a_valid = 1'b1; a_data = rand_word(); end
                    end
                    #1;
                    check_value($sformatf("i%0d_f%0d_k%0d", g, f, k),
                                {cfg_en, cfg_sclk, cfg_data, busy, done, a_ready, b_ready},
                                {expect_wave(k, w), 2'b00});
                    if (k == 1) check_value($sformatf("i%0d_f%0d_src", g, f), last_src, win);
                    if (cfg_sclk && !prev_sclk) begin
                        if (nrise < W) coll[nrise] = cfg_data;
                        nrise++;
                    end
                    prev_sclk = cfg_sclk;
                    if (f == RST_FRM && k == DIV + 1 + 2 * DIV * 20) begin
                        #2;
                        reset = 1'b1;
                        #1;
                        check_value($sformatf("i%0d_midrst", g),
                                    {cfg_en, cfg_sclk, cfg_data, busy, done}, 5'b00000);
                        aborted = 1'b1;
                    end
                end

                if (aborted) begin
                    @(posedge clk);
                    @(negedge clk);
                    reset    = 1'b0;
                    mdl_last = 1'b1;
                end else begin
                    check_value($sformatf("i%0d_f%0d_nrise", g, f), nrise, W);
                    check_value($sformatf("i%0d_f%0d_word", g, f), coll, w);
                    @(negedge clk);
                end
            end
            fin_count++;
        end
    end

    initial begin : supervisor
        for (int i = 0; i < 20000 && fin_count < 2; i++) @(posedge clk);
        check_value("finish_timeout", fin_count, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
